// File: rtl/dpb_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : dpb_stream_reader
// Description : Read-side burst engine for the 2048x9 HDMI dual-port RAM.
//               Issues reads, absorbs the 1-cycle RAM latency through a skid
//               FIFO and streams words out over valid/ready.
//               Optional macro DPB_READER_PARITY_EN enables the sticky
//               even-parity checker on popped words.
// Revision    : 1.0 - initial release
// ============================================================================
module dpb_stream_reader #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 9,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              ram_ce,
    output logic              ram_oce,
    output logic [ADDR_W-1:0] ram_ad,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              parity_err
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W:0]    c_ONE   = (ADDR_W+1)'(1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_FLUSH = 2'd3;

    logic [1:0]         r_state;
    logic [ADDR_W-1:0]  r_base;
    logic [ADDR_W:0]    r_len;
    logic [ADDR_W:0]    r_issue_cnt;
    logic [ADDR_W:0]    r_pop_cnt;
    logic               r_inflight;
    logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;

    logic               w_pop;
    logic               w_issue;
    logic               w_last_issue;
    logic [c_CNT_W-1:0] w_occupancy;

    assign m_valid = (r_count != '0);
    assign w_pop   = m_valid & m_ready;
    assign m_data  = r_mem[r_rptr];
    assign m_last  = m_valid && ((r_pop_cnt + c_ONE) == r_len);

    // Credit check counts the word in flight from the RAM and frees the slot
    // being popped this cycle, so a full FIFO that drains can still issue.
    assign w_occupancy  = r_count + c_CNT_W'(r_inflight) - c_CNT_W'(w_pop);
    assign w_issue      = (r_state == c_RUN) && (r_issue_cnt < r_len) && (w_occupancy < c_DEPTH);
    assign w_last_issue = w_issue && ((r_issue_cnt + c_ONE) == r_len);

    assign ram_ce  = w_issue;
    assign ram_oce = 1'b1;
    assign ram_ad  = r_base + r_issue_cnt[ADDR_W-1:0];

    assign busy = (r_state != c_IDLE);
    assign done = (r_state == c_FLUSH);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= c_IDLE;
            r_base      <= '0;
            r_len       <= '0;
            r_issue_cnt <= '0;
            r_pop_cnt   <= '0;
            r_inflight  <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) r_issue_cnt <= r_issue_cnt + c_ONE;
            if (w_pop)   r_pop_cnt   <= r_pop_cnt + c_ONE;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_base      <= base_addr;
                        r_len       <= length;
                        r_issue_cnt <= '0;
                        r_pop_cnt   <= '0;
                        r_state     <= (length == '0) ? c_FLUSH : c_RUN;
                    end
                end
                c_RUN: begin
                    if (w_last_issue) r_state <= c_DRAIN;
                end
                c_DRAIN: begin
                    if (w_pop && m_last) r_state <= c_FLUSH;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Skid FIFO: RAM data is captured the cycle after its read strobe.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (r_inflight) begin
                r_mem[r_wptr] <= ram_dout;
                r_wptr        <= r_wptr + c_PTR_W'(1);
            end
            if (w_pop) r_rptr <= r_rptr + c_PTR_W'(1);
            r_count <= r_count + c_CNT_W'(r_inflight) - c_CNT_W'(w_pop);
        end
    end

`ifdef DPB_READER_PARITY_EN
    logic r_parity_err;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_parity_err <= 1'b0;
        end else if (w_pop && (^m_data)) begin
            r_parity_err <= 1'b1;
        end
    end

    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dpb_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_dpb_stream_reader
// Description : Randomized bench for dpb_stream_reader with a RAM model and
//               a word-queue reference built from the burst rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dpb_stream_reader;

    localparam int c_ADDR_W = 11;
    localparam int c_DATA_W = 9;
    localparam int c_RAM_N  = 2048;

    logic                clk = 1'b0;
    logic                resetn = 1'b0;
    logic                start = 1'b0;
    logic [c_ADDR_W-1:0] base_addr = '0;
    logic [c_ADDR_W:0]   length = '0;
    logic                busy, done, ram_ce, ram_oce;
    logic [c_ADDR_W-1:0] ram_ad;
    logic [c_DATA_W-1:0] ram_dout = '0;
    logic                m_valid;
    logic                m_ready = 1'b0;
    logic [c_DATA_W-1:0] m_data;
    logic                m_last, parity_err;

    int checks = 0;
    int failures = 0;
    bit exp_perr = 1'b0;
    logic [c_DATA_W-1:0] ram [c_RAM_N];

    dpb_stream_reader #(.ADDR_W(c_ADDR_W), .DATA_W(c_DATA_W), .FIFO_DEPTH(4)) dut (
        .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_ad(ram_ad),
        .ram_dout(ram_dout), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_ce) ram_dout <= ram[ram_ad];

    function automatic logic [c_DATA_W-1:0] good_word(input logic [7:0] lo);
        return {^lo, lo};
    endfunction

    task automatic fill_random();
        for (int i = 0; i < c_RAM_N; i++) ram[i] = good_word(8'($urandom));
    endtask

    // One burst, checked cycle by cycle against the expected word queue.
    task automatic run_burst(input int base, input int len, input int mode,
                             input int abort_pops, input bit poke);
        logic [c_DATA_W-1:0] exp_q[$];
        int issued = 0, popped = 0, cyc = 0, done_cnt = 0;
        int first_valid = -1, first_pop = -1, last_pop = -1;
        int budget = 100 + 6 * len;
        bit stall = 0, popping;
        logic [c_DATA_W-1:0] stall_data = '0;
        logic stall_last = 0;
        for (int j = 0; j < len; j++) exp_q.push_back(ram[(base + j) % c_RAM_N]);
        @(negedge clk);
        base_addr = 11'(base);
        length    = 12'(len);
        start     = 1'b1;
        m_ready   = 1'b1;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (poke && cyc == 4) begin
                start = 1'b1; base_addr = ~base_addr; length = 12'd5;
            end
            case (mode)
                0: m_ready = 1'b1;
                1: m_ready = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
                default: m_ready = 1'($urandom);
            endcase
            #1;
            checks++;
            if (parity_err !== exp_perr) begin
                failures++; $display("FAIL parity_err cyc=%0d got=%b exp=%b", cyc, parity_err, exp_perr);
            end
            checks++;
            if (busy !== 1'b1) begin
                failures++; $display("FAIL busy_in_burst cyc=%0d got=%b exp=1", cyc, busy);
            end
            if (ram_ce) begin
                checks++;
                if (issued >= len || ram_ad !== 11'((base + issued) % c_RAM_N)) begin
                    failures++;
                    $display("FAIL ram_ad idx=%0d got=%0d exp=%0d len=%0d", issued, ram_ad, (base + issued) % c_RAM_N, len);
                end
                issued++;
            end
            if (stall) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== stall_data || m_last !== stall_last) begin
                    failures++;
                    $display("FAIL hold_stable cyc=%0d got=%b/%h/%b exp=1/%h/%b", cyc, m_valid, m_data, m_last, stall_data, stall_last);
                end
            end
            popping = m_valid && m_ready;
            if (m_valid) begin
                if (first_valid < 0) first_valid = cyc;
                checks++;
                if (popped >= len) begin
                    failures++; $display("FAIL extra_word cyc=%0d got=%h exp=none", cyc, m_data);
                end else if (m_data !== exp_q[popped] || m_last !== (popped == len - 1)) begin
                    failures++;
                    $display("FAIL word idx=%0d got=%h/last%b exp=%h/last%b", popped, m_data, m_last, exp_q[popped], (popped == len - 1));
                end
            end
            stall      = m_valid && !m_ready;
            stall_data = m_data;
            stall_last = m_last;
            if (popping) begin
`ifdef DPB_READER_PARITY_EN
                if (^m_data) exp_perr = 1'b1;
`endif
                popped++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
            checks++;
            if (issued - popped > 4) begin
                failures++; $display("FAIL occupancy cyc=%0d got=%0d exp<=4", cyc, issued - popped);
            end
            if (done) begin
                done_cnt++;
                checks++;
                if (popped != len || cyc != ((len == 0) ? 1 : last_pop + 1)) begin
                    failures++;
                    $display("FAIL done_timing cyc=%0d got_popped=%0d exp_popped=%0d last_pop=%0d", cyc, popped, len, last_pop);
                end
                if (poke) begin
                    start = 1'b1; base_addr = 11'd7; length = 12'd3;
                end
                break;
            end
            if (abort_pops > 0 && popped == abort_pops) return;
        end
        if (cyc >= budget) begin
            failures++; $display("FAIL timeout got_cyc=%0d exp_done_before=%0d", cyc, budget);
        end
        checks++;
        if (popped != len || issued != len || done_cnt != 1) begin
            failures++;
            $display("FAIL burst_totals got=%0d/%0d/%0d exp=%0d/%0d/1", popped, issued, done_cnt, len, len);
        end
        checks++;
        if (first_valid != ((len == 0) ? -1 : 3)) begin
            failures++; $display("FAIL first_valid_latency got=%0d exp=%0d", first_valid, (len == 0) ? -1 : 3);
        end
        if (mode == 0 && len > 0) begin
            checks++;
            if (last_pop - first_pop != len - 1) begin
                failures++; $display("FAIL throughput got_span=%0d exp=%0d", last_pop - first_pop, len - 1);
            end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            checks++;
            if (busy !== 1'b0 || m_valid !== 1'b0 || ram_ce !== 1'b0 || done !== 1'b0) begin
                failures++;
                $display("FAIL post_idle k=%0d got=%b%b%b%b exp=0000", k, busy, m_valid, ram_ce, done);
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if ({busy, done, ram_ce, m_valid, m_last, parity_err} !== 6'b0 || ram_ad !== '0 ||
            m_data !== '0 || ram_oce !== 1'b1) begin
            failures++;
            $display("FAIL %s got=%b%b%b%b%b%b ad=%0d data=%h oce=%b exp=000000 ad=0 data=000 oce=1",
                     tag, busy, done, ram_ce, m_valid, m_last, parity_err, ram_ad, m_data, ram_oce);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_values("reset_state");
        resetn = 1'b1;
        exp_perr = 1'b0;
    endtask

    task automatic test_basic();
        for (int i = 0; i < c_RAM_N; i++)
`ifdef DPB_READER_PARITY_EN
            ram[i] = good_word(i[7:0]);
`else
            ram[i] = 9'(i);
`endif
        run_burst(16'h010, 8, 0, 0, 0);
    endtask

    task automatic test_wrap();
        fill_random();
        run_burst(2046, 4, 0, 0, 0);
        run_burst(1500, c_RAM_N, 0, 0, 0);
    endtask

    task automatic test_backpressure();
        fill_random();
        run_burst(int'($urandom_range(0, 2047)), 6, 1, 0, 0);
        run_burst(int'($urandom_range(0, 2047)), 17, 1, 0, 0);
    endtask

    task automatic test_zero_length();
        run_burst(100, 0, 0, 0, 0);
    endtask

    task automatic test_start_ignored();
        fill_random();
        run_burst(300, 9, 2, 0, 1);
    endtask

    task automatic test_random();
        fill_random();
        for (int n = 0; n < 12; n++)
            run_burst(int'($urandom_range(0, 2047)), int'($urandom_range(1, 40)), 2, 0, 0);
    endtask

    task automatic test_abort();
        fill_random();
        run_burst(40, 16, 0, 5, 0);
        #2;
        resetn = 1'b0;
        #1;
        check_reset_values("async_abort");
        exp_perr = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        m_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if (m_valid !== 1'b0 || done !== 1'b0 || ram_ce !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL after_abort k=%0d got=%b%b%b%b exp=0000", k, m_valid, done, ram_ce, busy);
            end
        end
        run_burst(40, 16, 2, 0, 0);
    endtask

    task automatic test_parity();
        fill_random();
        ram[3] = good_word(8'($urandom)) ^ 9'h001;
        run_burst(0, 5, 0, 0, 0);
        repeat (5) @(negedge clk);
        #1;
        checks++;
`ifdef DPB_READER_PARITY_EN
        if (parity_err !== 1'b1) begin
            failures++; $display("FAIL parity_sticky got=%b exp=1", parity_err);
        end
`else
        if (parity_err !== 1'b0) begin
            failures++; $display("FAIL parity_disabled got=%b exp=0", parity_err);
        end
`endif
        run_burst(10, 6, 2, 0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_length();
        test_start_ignored();
        test_random();
        test_abort();
        test_parity();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
